// File: rtl/ysyx_23060184_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060184_pc_gen
// Brief    : Program-counter generator and fetch sequencer for the NPC front
//            end. Issues one fetch at a time over Pvalid/Iready, advances the
//            PC by 4 on each completion, and applies branch and trap
//            redirects. A fetch already in flight when a redirect lands is
//            tagged stale so that decode drops it.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060184_pc_gen #(
  parameter int unsigned               DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]     RESET_PC   = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  resetn,
  // fetch request side
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic                  Pvalid,
  input  logic                  Iready,
  // instruction return side
  input  logic                  Ivalid,
  input  logic                  Dready,
  output logic [DATA_WIDTH-1:0] fetch_pc_o,
  output logic                  kill_o,
  // redirects
  input  logic                  redir_valid,
  input  logic [DATA_WIDTH-1:0] redir_pc,
  input  logic                  trap_valid,
  input  logic [DATA_WIDTH-1:0] trap_pc,
  // halt / status
  input  logic                  halt_i,
  output logic                  halted_o,
  output logic [63:0]           inst_cnt_o
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  // Instructions are word aligned: the PC steps by 4 and redirect targets
  // always have their two low bits cleared.
  localparam logic [DATA_WIDTH-1:0] c_PC_STEP    = {{(DATA_WIDTH-3){1'b0}}, 3'b100};
  localparam logic [DATA_WIDTH-1:0] c_ALIGN_MASK = {{(DATA_WIDTH-2){1'b1}}, 2'b00};

  state_t                  r_state;
  state_t                  w_next_state;
  logic                    w_next_pvalid;

  logic [DATA_WIDTH-1:0]   r_pc;
  logic [DATA_WIDTH-1:0]   r_fetch_pc;
  logic                    r_pvalid;
  logic                    r_stale;
  logic                    r_pend_valid;
  logic                    r_pend_trap;
  logic [DATA_WIDTH-1:0]   r_pend_pc;
  logic [63:0]             r_inst_cnt;

  logic                    w_redir;
  logic [DATA_WIDTH-1:0]   w_tgt_raw;
  logic [DATA_WIDTH-1:0]   w_tgt;
  logic                    w_accept;
  logic                    w_complete;
  logic                    w_kill;
  logic                    w_pend_write;

  // Effective redirect for this cycle: a trap outranks a branch.
  always_comb begin
    w_redir   = trap_valid || redir_valid;
    w_tgt_raw = trap_valid ? trap_pc : redir_pc;
    w_tgt     = w_tgt_raw & c_ALIGN_MASK;
  end

  // Handshake events and the stale-instruction kill. Ivalid outside WAIT has
  // no meaning to this block, so it can neither complete nor be killed.
  always_comb begin
    w_accept   = (r_state == S_ISSUE) && r_pvalid && Iready;
    w_complete = (r_state == S_WAIT) && Ivalid && Dready;
    w_kill     = (r_state == S_WAIT) && Ivalid && (r_stale || w_redir);
    // A pending trap target may only be replaced by another trap.
    w_pend_write = trap_valid || !(r_pend_valid && r_pend_trap);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic. An accepted request takes precedence over halt so
  // the fetch unit never sees a request that this block then abandons.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_BOOT: begin
        w_next_state = S_ISSUE;
      end
      S_ISSUE: begin
        if (w_accept) begin
          w_next_state = S_WAIT;
        end else if (halt_i) begin
          w_next_state = S_HALT;
        end
      end
      S_WAIT: begin
        if (w_complete) begin
          w_next_state = halt_i ? S_HALT : S_ISSUE;
        end
      end
      S_HALT: begin
        w_next_state = S_HALT;
      end
      default: begin
        w_next_state = S_BOOT;
      end
    endcase
    w_next_pvalid = (w_next_state == S_ISSUE);
  end

  // Pvalid is registered and high exactly while the FSM sits in ISSUE.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pvalid <= 1'b0;
    end else begin
      r_pvalid <= w_next_pvalid;
    end
  end

  // PC, in-flight PC, stale flag and pending redirect target.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pc         <= RESET_PC;
      r_fetch_pc   <= RESET_PC;
      r_stale      <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_trap  <= 1'b0;
      r_pend_pc    <= RESET_PC;
    end else begin
      case (r_state)
        S_ISSUE: begin
          if (w_accept) begin
            // The accepted request carries the old PC; a coincident redirect
            // is deferred until that fetch returns.
            r_fetch_pc <= r_pc;
            if (w_redir) begin
              r_stale      <= 1'b1;
              r_pend_valid <= 1'b1;
              r_pend_trap  <= trap_valid;
              r_pend_pc    <= w_tgt;
            end else begin
              r_stale      <= 1'b0;
              r_pend_valid <= 1'b0;
              r_pend_trap  <= 1'b0;
            end
          end else if (w_redir) begin
            // Nothing issued yet: retarget the request directly.
            r_pc <= w_tgt;
          end
        end
        S_WAIT: begin
          if (w_complete) begin
            if (w_redir) begin
              r_pc <= w_tgt;
            end else if (r_pend_valid) begin
              r_pc <= r_pend_pc;
            end else begin
              r_pc <= r_pc + c_PC_STEP;
            end
            r_stale      <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_trap  <= 1'b0;
          end else if (w_redir) begin
            r_stale <= 1'b1;
            if (w_pend_write) begin
              r_pend_valid <= 1'b1;
              r_pend_trap  <= trap_valid;
              r_pend_pc    <= w_tgt;
            end
          end
        end
        default: begin
          // BOOT and HALT hold the datapath.
        end
      endcase
    end
  end

  // Retired-fetch counter: only instructions that decode actually keeps.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_inst_cnt <= 64'd0;
    end else if (w_complete && !w_kill) begin
      r_inst_cnt <= r_inst_cnt + 64'd1;
    end
  end

  // Output drive.
  always_comb begin
    pc_o       = r_pc;
    Pvalid     = r_pvalid;
    fetch_pc_o = r_fetch_pc;
    kill_o     = w_kill;
    halted_o   = (r_state == S_HALT);
    inst_cnt_o = r_inst_cnt;
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060184_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_23060184_pc_gen
// Brief    : Directed, table-driven bench for the PC generator. Each table
//            record describes one fetch (issue PC, redirect event, expected
//            kill, next PC, instruction count); hand-written sequences cover
//            ISSUE-time redirects, ignored Ivalid, halt and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060184_pc_gen;

  localparam int unsigned c_W = 32;

  // Redirect event applied during a fetch.
  localparam logic [2:0] c_EV_NONE = 3'd0; // no redirect
  localparam logic [2:0] c_EV_BR   = 3'd1; // branch in first WAIT cycle
  localparam logic [2:0] c_EV_TR   = 3'd2; // trap in first WAIT cycle
  localparam logic [2:0] c_EV_CO   = 3'd3; // branch coincident with completion
  localparam logic [2:0] c_EV_COT  = 3'd4; // trap coincident with completion
  localparam logic [2:0] c_EV_TRBR = 3'd5; // trap+branch, then branch to 0300
  localparam logic [2:0] c_EV_BRTR = 3'd6; // branch, then trap next cycle
  localparam logic [2:0] c_EV_ACC  = 3'd7; // branch on the acceptance edge

  typedef struct {
    logic [2:0]     evt;
    logic [c_W-1:0] tgt_a;
    logic [c_W-1:0] tgt_b;
    logic           halt;
    logic [c_W-1:0] fpc;
    logic           kill;
    logic [c_W-1:0] nxt;
    logic [63:0]    cnt;
  } vec_t;

  logic           clk;
  logic           resetn;
  logic [c_W-1:0] pc_o;
  logic           Pvalid;
  logic           Iready;
  logic           Ivalid;
  logic           Dready;
  logic [c_W-1:0] fetch_pc_o;
  logic           kill_o;
  logic           redir_valid;
  logic [c_W-1:0] redir_pc;
  logic           trap_valid;
  logic [c_W-1:0] trap_pc;
  logic           halt_i;
  logic           halted_o;
  logic [63:0]    inst_cnt_o;

  int checks;
  int failures;
  vec_t vecs [14];

  ysyx_23060184_pc_gen #(
    .DATA_WIDTH (32),
    .RESET_PC   (32'h8000_0000)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .pc_o        (pc_o),
    .Pvalid      (Pvalid),
    .Iready      (Iready),
    .Ivalid      (Ivalid),
    .Dready      (Dready),
    .fetch_pc_o  (fetch_pc_o),
    .kill_o      (kill_o),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .trap_valid  (trap_valid),
    .trap_pc     (trap_pc),
    .halt_i      (halt_i),
    .halted_o    (halted_o),
    .inst_cnt_o  (inst_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic clear_redirs();
    redir_valid = 1'b0;
    trap_valid  = 1'b0;
  endtask

  // One full fetch: issue, three WAIT cycles with the return on the third.
  task automatic run_vec(input int idx);
    vec_t v;
    int   n;
    v = vecs[idx];
    n = 0;
    while (!Pvalid && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk($sformatf("v%0d_issue_pvalid", idx), 64'(Pvalid), 64'd1);
    chk($sformatf("v%0d_issue_pc", idx), 64'(pc_o), 64'(v.fpc));
    Iready = 1'b1;
    if (v.evt == c_EV_ACC) begin
      redir_valid = 1'b1;
      redir_pc    = v.tgt_a;
    end
    // WAIT cycle 1
    @(negedge clk);
    Iready = 1'b0;
    clear_redirs();
    #1;
    chk($sformatf("v%0d_wait_pvalid", idx), 64'(Pvalid), 64'd0);
    case (v.evt)
      c_EV_BR:   begin redir_valid = 1'b1; redir_pc = v.tgt_a; end
      c_EV_TR:   begin trap_valid  = 1'b1; trap_pc  = v.tgt_a; end
      c_EV_TRBR: begin trap_valid  = 1'b1; trap_pc  = v.tgt_a;
                       redir_valid = 1'b1; redir_pc = v.tgt_b; end
      c_EV_BRTR: begin redir_valid = 1'b1; redir_pc = v.tgt_b; end
      default:   begin end
    endcase
    if (v.halt) halt_i = 1'b1;
    #1;
    chk($sformatf("v%0d_wait_nokill", idx), 64'(kill_o), 64'd0);
    // WAIT cycle 2
    @(negedge clk);
    clear_redirs();
    case (v.evt)
      c_EV_TRBR: begin redir_valid = 1'b1; redir_pc = 32'h8000_0300; end
      c_EV_BRTR: begin trap_valid  = 1'b1; trap_pc  = v.tgt_a; end
      default:   begin end
    endcase
    // WAIT cycle 3: instruction returns
    @(negedge clk);
    clear_redirs();
    Ivalid = 1'b1;
    Dready = 1'b1;
    case (v.evt)
      c_EV_CO:  begin redir_valid = 1'b1; redir_pc = v.tgt_a; end
      c_EV_COT: begin trap_valid  = 1'b1; trap_pc  = v.tgt_a; end
      default:  begin end
    endcase
    #1;
    chk($sformatf("v%0d_kill", idx), 64'(kill_o), 64'(v.kill));
    chk($sformatf("v%0d_fetch_pc", idx), 64'(fetch_pc_o), 64'(v.fpc));
    @(negedge clk);
    clear_redirs();
    Ivalid = 1'b0;
    Dready = 1'b0;
    halt_i = 1'b0;
    #1;
    chk($sformatf("v%0d_next_pc", idx), 64'(pc_o), 64'(v.nxt));
    chk($sformatf("v%0d_cnt", idx), inst_cnt_o, v.cnt);
    if (v.halt) begin
      chk($sformatf("v%0d_halted", idx), 64'(halted_o), 64'd1);
      chk($sformatf("v%0d_halt_pvalid", idx), 64'(Pvalid), 64'd0);
    end else begin
      chk($sformatf("v%0d_next_pvalid", idx), 64'(Pvalid), 64'd1);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_pc"}, 64'(pc_o), 64'h8000_0000);
    chk({tag, "_fetch_pc"}, 64'(fetch_pc_o), 64'h8000_0000);
    chk({tag, "_pvalid"}, 64'(Pvalid), 64'd0);
    chk({tag, "_kill"}, 64'(kill_o), 64'd0);
    chk({tag, "_halted"}, 64'(halted_o), 64'd0);
    chk({tag, "_cnt"}, inst_cnt_o, 64'd0);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    resetn      = 1'b0;
    Iready      = 1'b0;
    Ivalid      = 1'b0;
    Dready      = 1'b0;
    redir_valid = 1'b0;
    redir_pc    = '0;
    trap_valid  = 1'b0;
    trap_pc     = '0;
    halt_i      = 1'b0;

    //              evt        tgt_a          tgt_b          halt  fpc            kill  nxt            cnt
    vecs[0]  = '{c_EV_NONE, 32'h0,         32'h0,         1'b0, 32'h8000_0000, 1'b0, 32'h8000_0004, 64'd1};
    vecs[1]  = '{c_EV_NONE, 32'h0,         32'h0,         1'b0, 32'h8000_0004, 1'b0, 32'h8000_0008, 64'd2};
    vecs[2]  = '{c_EV_NONE, 32'h0,         32'h0,         1'b0, 32'h8000_0008, 1'b0, 32'h8000_000C, 64'd3};
    vecs[3]  = '{c_EV_BR,   32'h8000_0100, 32'h0,         1'b0, 32'h8000_000C, 1'b1, 32'h8000_0100, 64'd3};
    vecs[4]  = '{c_EV_TR,   32'h8000_0203, 32'h0,         1'b0, 32'h8000_0100, 1'b1, 32'h8000_0200, 64'd3};
    vecs[5]  = '{c_EV_CO,   32'h8000_0302, 32'h0,         1'b0, 32'h8000_0200, 1'b1, 32'h8000_0300, 64'd3};
    vecs[6]  = '{c_EV_NONE, 32'h0,         32'h0,         1'b0, 32'h8000_0300, 1'b0, 32'h8000_0304, 64'd4};
    vecs[7]  = '{c_EV_COT,  32'h8000_0400, 32'h0,         1'b0, 32'h8000_0304, 1'b1, 32'h8000_0400, 64'd4};
    vecs[8]  = '{c_EV_TRBR, 32'h8000_0200, 32'h8000_0100, 1'b0, 32'h8000_0400, 1'b1, 32'h8000_0200, 64'd4};
    vecs[9]  = '{c_EV_BRTR, 32'h8000_0600, 32'h8000_0500, 1'b0, 32'h8000_0200, 1'b1, 32'h8000_0600, 64'd4};
    vecs[10] = '{c_EV_ACC,  32'h8000_0700, 32'h0,         1'b0, 32'h8000_0600, 1'b1, 32'h8000_0700, 64'd4};
    vecs[11] = '{c_EV_NONE, 32'h0,         32'h0,         1'b0, 32'h8000_0700, 1'b0, 32'h8000_0704, 64'd5};
    vecs[12] = '{c_EV_NONE, 32'h0,         32'h0,         1'b0, 32'h8000_0100, 1'b0, 32'h8000_0104, 64'd6};
    vecs[13] = '{c_EV_NONE, 32'h0,         32'h0,         1'b1, 32'h8000_0104, 1'b0, 32'h8000_0108, 64'd7};

    // Reset values, then one BOOT cycle with Pvalid low.
    repeat (3) @(negedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("boot_pvalid", 64'(Pvalid), 64'd0);
    @(negedge clk); #1;
    chk("issue_after_boot", 64'(Pvalid), 64'd1);

    for (int i = 0; i < 12; i++) run_vec(i);

    // Redirect in ISSUE while Iready is low; stray Ivalid is ignored.
    Iready      = 1'b0;
    redir_valid = 1'b1;
    redir_pc    = 32'h8000_0103;
    Ivalid      = 1'b1;
    Dready      = 1'b1;
    #1;
    chk("issue_ivalid_nokill", 64'(kill_o), 64'd0);
    @(negedge clk);
    clear_redirs();
    Ivalid = 1'b0;
    Dready = 1'b0;
    #1;
    chk("issue_redir_pc", 64'(pc_o), 64'h8000_0100);
    chk("issue_redir_pvalid", 64'(Pvalid), 64'd1);
    chk("issue_ivalid_nocount", inst_cnt_o, 64'd5);

    for (int i = 12; i < 14; i++) run_vec(i);

    // HALT ignores redirects and returned instructions.
    redir_valid = 1'b1;
    redir_pc    = 32'h8000_0900;
    @(negedge clk);
    clear_redirs();
    Ivalid = 1'b1;
    Dready = 1'b1;
    Iready = 1'b1;
    repeat (3) @(negedge clk);
    Ivalid = 1'b0;
    Dready = 1'b0;
    Iready = 1'b0;
    #1;
    chk("halt_hold_pc", 64'(pc_o), 64'h8000_0108);
    chk("halt_hold_pvalid", 64'(Pvalid), 64'd0);
    chk("halt_hold_halted", 64'(halted_o), 64'd1);
    chk("halt_hold_cnt", inst_cnt_o, 64'd7);

    // Reset leaves HALT.
    resetn = 1'b0;
    @(negedge clk); #1;
    check_reset_state("rereset");
    resetn = 1'b1;

    // halt_i in ISSUE with no acceptance goes straight to HALT.
    @(negedge clk); #1;
    chk("halt_issue_pre_pvalid", 64'(Pvalid), 64'd1);
    halt_i = 1'b1;
    @(negedge clk);
    halt_i = 1'b0;
    #1;
    chk("halt_issue_halted", 64'(halted_o), 64'd1);
    chk("halt_issue_pvalid", 64'(Pvalid), 64'd0);
    chk("halt_issue_pc", 64'(pc_o), 64'h8000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
